// File: rtl/demux_pkg.sv
// Shared definitions for the 7-way write distributor.
package demux_pkg;

  localparam int         CH_COUNT    = 7;
  localparam logic [2:0] SEL_INVALID = 3'b111;

  typedef logic [2:0]          sel_t;
  typedef logic [CH_COUNT-1:0] chmask_t;

  // One-hot slot select; the illegal code and an idle strobe both give an empty mask.
  function automatic chmask_t decode_sel(input logic en, input sel_t sel);
    chmask_t m;
    m = '0;
    for (int i = 0; i < CH_COUNT; i++) begin
      m[i] = en && (sel == sel_t'(i));
    end
    return m;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One holding slot: a data register plus its valid bit.
// An ack frees the slot before a same-cycle write, so write+ack leaves it valid.
module demux_slot #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic              ack,
  input  logic [DATA_W-1:0] data_In,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              blocked
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;

  // Next-state: load on write, drop valid on ack unless refilled this cycle.
  always_comb begin
    data_d  = wr ? data_In : data_q;
    valid_d = wr | (valid_q & ~ack);
  end

  // Slot registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data    = data_q;
  assign valid   = valid_q;
  // Occupied and not being drained this cycle: a write now would collide.
  assign blocked = valid_q & ~ack;

endmodule

// File: rtl/demux32_06.sv
// Registered 1-to-7 distributor of DATA_W words into acknowledged holding slots.
// Optional macro DEMUX32_OVERFLOW_PROTECT_EN: writes to an occupied, unacked slot
// are dropped and flagged in a sticky overflow bit; otherwise they overwrite.
module demux32_06
  import demux_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [2:0]          signal,
  input  logic [DATA_W-1:0]   data_In,
  input  logic [CH_COUNT-1:0] rd_ack,
  input  logic                clr_ovf,
  output logic [DATA_W-1:0]   data_0,
  output logic [DATA_W-1:0]   data_1,
  output logic [DATA_W-1:0]   data_2,
  output logic [DATA_W-1:0]   data_3,
  output logic [DATA_W-1:0]   data_4,
  output logic [DATA_W-1:0]   data_5,
  output logic [DATA_W-1:0]   data_6,
  output logic [CH_COUNT-1:0] valid,
  output logic                sel_err,
  output logic                overflow
);

  chmask_t           wr_hit;
  chmask_t           slot_wr;
  chmask_t           slot_blocked;
  chmask_t           slot_valid;
  logic [DATA_W-1:0] slot_data [CH_COUNT];

  logic sel_err_q, sel_err_d;
  logic overflow_q, overflow_d;

  assign wr_hit = decode_sel(wr_en, sel_t'(signal));

  // Write gating and overflow tracking for the selected configuration.
  always_comb begin
`ifdef DEMUX32_OVERFLOW_PROTECT_EN
    slot_wr    = wr_hit & ~slot_blocked;
    overflow_d = (overflow_q & ~clr_ovf) | (|(wr_hit & slot_blocked));
`else
    slot_wr    = wr_hit;
    // Overwrite mode: the flag never sets; inputs are folded in only so none dangle.
    overflow_d = overflow_q & ~clr_ovf & ~(|(wr_hit & slot_blocked));
`endif
    sel_err_d  = wr_en && (signal == SEL_INVALID);
  end

  // Status registers: one-cycle illegal-code pulse and sticky overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_err_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      sel_err_q  <= sel_err_d;
      overflow_q <= overflow_d;
    end
  end

  for (genvar k = 0; k < CH_COUNT; k++) begin : g_slot
    demux_slot #(.DATA_W(DATA_W)) u_slot (
      .clk     (clk),
      .reset   (reset),
      .wr      (slot_wr[k]),
      .ack     (rd_ack[k]),
      .data_In (data_In),
      .data    (slot_data[k]),
      .valid   (slot_valid[k]),
      .blocked (slot_blocked[k])
    );
  end

  assign data_0   = slot_data[0];
  assign data_1   = slot_data[1];
  assign data_2   = slot_data[2];
  assign data_3   = slot_data[3];
  assign data_4   = slot_data[4];
  assign data_5   = slot_data[5];
  assign data_6   = slot_data[6];
  assign valid    = slot_valid;
  assign sel_err  = sel_err_q;
  assign overflow = overflow_q;

endmodule

// File: doc/demux32_06.md
# demux32_06

Registered 1-to-7 distributor for 32-bit datapath values, the write-side counterpart of the 7-way source selectors. A producer presents one word plus a 3-bit `signal` code. The block latches the word into the addressed one of seven holding slots and marks that slot valid. Each consumer drains its slot with a per-channel acknowledge. It sits between a shared result bus (ALU/memory return) and the per-destination staging registers of the multicycle datapath.

## Interface
Parameters:
- `DATA_W`, 32, width of each data word and slot.

Ports:
- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  write strobe; qualifies `signal` and `data_In`.
- `signal`  in  3  destination code: 0..6 select slot 0..6; 7 is illegal.
- `data_In`  in  DATA_W  word to store.
- `rd_ack`  in  7  per-slot consume acknowledge; bit k clears slot k valid.
- `clr_ovf`  in  1  clears the sticky overflow flag (only meaningful with the macro).
- `data_0` .. `data_6`  out  DATA_W each  slot contents, registered.
- `valid`  out  7  bit k high while slot k holds unconsumed data.
- `sel_err`  out  1  one-cycle pulse after a write with `signal`==7.
- `overflow`  out  1  sticky flag, set when a write is blocked.

## Operation
- Reset (`reset`==0, asynchronous) forces the following; all are held while reset is low:
  - `data_0`..`data_6` = 0
  - `valid` = 7'b0
  - `sel_err` = 0
  - `overflow` = 0
- Write, on a clock edge with `wr_en`==1 and `signal`=k≤6:
  - `data_k` <= `data_In`
  - `valid[k]` <= 1
  - Other slots are unchanged.
- Illegal code (`wr_en`==1, `signal`==7): no slot changes; `sel_err`=1 for exactly the next cycle.
- Consume: on a clock edge with `rd_ack[k]`==1, `valid[k]` <= 0. The data is retained.
  - An ack on a slot that is not valid is ignored.
  - Any subset of `rd_ack` bits may be active in the same cycle.
- Write and ack to the same slot in the same cycle:
  - The slot is treated as freed before the write.
  - The new data is stored, `valid[k]` stays 1, and `overflow` is not affected.
- Write to slot k while `valid[k]`==1 with no ack: behaviour depends on the configuration (see below).
- `clr_ovf` and a new overflow event in the same cycle: the set wins, so `overflow` stays 1.
- No internal state beyond the slots, the valid bits, the `sel_err` register and the `overflow` register.

## Timing
- Write-to-output latency is 1 cycle. Data and valid appear after the capturing edge; there is no combinational path from `data_In` to the outputs.
- Ack-to-valid-clear latency is 1 cycle.
- Throughput is one write per cycle, to any slot. Back-to-back writes to different slots are all accepted.
- `sel_err` is high for exactly one cycle per illegal write. Consecutive illegal writes keep it high for consecutive cycles.
- Reset asserted mid-operation discards all pending slots immediately; there is no partial-write state.
- Reset deassertion is sampled synchronously by the integrator. The block accepts a write on the first edge after release.

## Configuration
- Macro: `DEMUX32_OVERFLOW_PROTECT_EN`.
- Defined:
  - A write to a valid, unacked slot is dropped. The slot keeps its old data and valid.
  - `overflow` <= 1 (sticky until `clr_ovf`).
- Undefined:
  - A write to a valid slot overwrites the data; valid stays 1.
  - `overflow` is constant 0 and `clr_ovf` is ignored.

## Structure
- Shared package `demux_pkg`:
  - `CH_COUNT`=7.
  - `SEL_INVALID`=3'b111.
  - `typedef logic [2:0] sel_t`.
  - `typedef logic [CH_COUNT-1:0] chmask_t`.
- One sub-module, `demux_slot`, holds a single DATA_W register plus its valid bit.
  - Inputs: `clk`, `reset`, `wr` (decoded write), `ack`, `data_In`.
  - Outputs: `data`, `valid`, `blocked`.
  - The top level instantiates it 7 times.
- The top level owns:
  - the one-hot decode of `signal`
  - the `sel_err` register
  - the `overflow` register

## Test plan
- Reset, then `wr_en`=1, `signal`=3, `data_In`=32'hDEADBEEF -> next cycle `data_3`=32'hDEADBEEF, `valid`=7'b0001000, all other slots 0.
- Write slots 0..6 on consecutive cycles with values 1..7, then assert `rd_ack`=7'h7F -> `valid` goes 7'h7F then 7'h00; data values are retained.
- Valid slot 5 holds 32'hA; write 32'hB to slot 5 with no ack:
  - with the macro -> `data_5`=32'hA and `overflow`=1;
  - without the macro -> `data_5`=32'hB and `overflow`=0.
- Same-cycle write 32'h55 and `rd_ack[2]` on valid slot 2 -> `data_2`=32'h55, `valid[2]`=1, `overflow`=0.
- `wr_en`=1, `signal`=7 -> `sel_err`=1 for one cycle; `valid` and all data unchanged.
- Assert `reset`=0 asynchronously between edges while slots are valid -> `valid`=0 and all outputs 0 immediately, before the next clock edge.
